// File: rtl/stage_wb_pkg.sv
// +----------------------------------------------------------------------------+
// | riscv_defines : shared types and encodings for the pipeline stages        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package riscv_defines;

   typedef enum logic [1:0] {
      RESULT_ALU = 2'd0,
      RESULT_PC4 = 2'd1,
      RESULT_CSR = 2'd2,
      RESULT_MEM = 2'd3
   } result_src_e;

   typedef struct packed {
      logic        regwrite;
      result_src_e resultsrc;
   } control_signal_t;

   typedef struct packed {
      logic        valid;
      logic [4:0]  cause;
      logic [31:0] tval;
   } trap_req_t;

   // Bit positions inside cnt_we / cnt_inhibit.
   localparam int CNT_MCYCLE_LO     = 0;
   localparam int CNT_MCYCLE_HI     = 1;
   localparam int CNT_MINSTRET_LO   = 2;
   localparam int CNT_MINSTRET_HI   = 3;
   localparam int CNT_INH_MCYCLE    = 0;
   localparam int CNT_INH_MINSTRET  = 1;

   typedef struct packed {
      logic            valid;
      control_signal_t cs;
      logic [31:0]     pc;
      logic [31:0]     pcplus4;
      logic [4:0]      rd;
      logic [31:0]     memresult;
      logic [31:0]     result;
      trap_req_t       trap;
   } mw_reg_t;

   function automatic mw_reg_t mw_bubble(input logic [31:0] pc);
      mw_reg_t b;
      b    = '0;
      b.pc = pc;
      return b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stage_wb_if.sv
// +----------------------------------------------------------------------------+
// | stage_wb_if : memory-to-writeback bundle, CSR counter ports and WB outputs |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface stage_wb_if;
   import riscv_defines::*;

   logic            valid_m;
   control_signal_t control_signal_m;
   logic [31:0]     pc_m;
   logic [31:0]     pcplus4_m;
   logic [4:0]      rd_m;
   logic [31:0]     memresult_m;
   logic [31:0]     result_m;
   trap_req_t       trap_req_m;
   logic            flush_w;
   logic [3:0]      cnt_we;
   logic [31:0]     cnt_wdata;
   logic [1:0]      cnt_inhibit;

   logic [31:0]     result_w;
   logic [4:0]      rd_w;
   logic            regwrite_w;
   logic [31:0]     pc_w;
   logic [31:0]     pcplus4_w;
   trap_req_t       trap_req_w;
   logic            retire_w;
   logic [63:0]     mcycle;
   logic [63:0]     minstret;

   modport master (
      output valid_m, control_signal_m, pc_m, pcplus4_m, rd_m, memresult_m,
             result_m, trap_req_m, flush_w, cnt_we, cnt_wdata, cnt_inhibit,
      input  result_w, rd_w, regwrite_w, pc_w, pcplus4_w, trap_req_w,
             retire_w, mcycle, minstret
   );

   modport slave (
      input  valid_m, control_signal_m, pc_m, pcplus4_m, rd_m, memresult_m,
             result_m, trap_req_m, flush_w, cnt_we, cnt_wdata, cnt_inhibit,
      output result_w, rd_w, regwrite_w, pc_w, pcplus4_w, trap_req_w,
             retire_w, mcycle, minstret
   );

endinterface

`default_nettype wire

// File: rtl/stage_wb_csr_counter64.sv
// +----------------------------------------------------------------------------+
// | csr_counter64 : 64-bit machine counter with independent half writes       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module csr_counter64 (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        inc,
   input  wire logic        we_lo,
   input  wire logic        we_hi,
   input  wire logic [31:0] wdata,
   output logic      [63:0] count
);

   logic [63:0] count_q;
   logic [63:0] count_d;
   logic [63:0] w_inc_val;

   // A written half overrides; the other half keeps its share of the increment.
   always_comb begin
      w_inc_val = count_q + 64'd1;
      count_d   = inc ? w_inc_val : count_q;
      if (we_lo) count_d[31:0]  = wdata;
      if (we_hi) count_d[63:32] = wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/stage_wb.sv
// +----------------------------------------------------------------------------+
// | stage_wb : writeback stage - M/W register, result select, mcycle/minstret |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module stage_wb
   import riscv_defines::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input wire logic  clk,
   input wire logic  reset,
   stage_wb_if.slave wb
);

   mw_reg_t stage_q;
   mw_reg_t stage_d;
   logic    w_retire;
   logic    w_mcycle_inc;
   logic    w_minstret_inc;

   always_comb begin
      stage_d           = mw_bubble(RESET_PC);
      if (!wb.flush_w) begin
         stage_d.valid     = wb.valid_m;
         stage_d.cs        = wb.control_signal_m;
         stage_d.pc        = wb.pc_m;
         stage_d.pcplus4   = wb.pcplus4_m;
         stage_d.rd        = wb.rd_m;
         stage_d.memresult = wb.memresult_m;
         stage_d.result    = wb.result_m;
         stage_d.trap      = wb.trap_req_m;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) stage_q <= mw_bubble(RESET_PC);
      else       stage_q <= stage_d;
   end

   assign w_retire = stage_q.valid & ~stage_q.trap.valid;

   assign wb.result_w   = (stage_q.cs.resultsrc == RESULT_MEM) ? stage_q.memresult
                                                               : stage_q.result;
   assign wb.rd_w       = stage_q.rd;
   assign wb.regwrite_w = w_retire & stage_q.cs.regwrite & (stage_q.rd != 5'd0);
   assign wb.pc_w       = stage_q.pc;
   assign wb.pcplus4_w  = stage_q.pcplus4;
   assign wb.trap_req_w = stage_q.valid ? stage_q.trap : '0;
   assign wb.retire_w   = w_retire;

   // minstret counts the instruction in WB at this edge, so it lags retire_w by one cycle.
   assign w_mcycle_inc   = ~wb.cnt_inhibit[CNT_INH_MCYCLE];
   assign w_minstret_inc = w_retire & ~wb.cnt_inhibit[CNT_INH_MINSTRET];

   csr_counter64 u_mcycle (
      .clk   (clk),
      .reset (reset),
      .inc   (w_mcycle_inc),
      .we_lo (wb.cnt_we[CNT_MCYCLE_LO]),
      .we_hi (wb.cnt_we[CNT_MCYCLE_HI]),
      .wdata (wb.cnt_wdata),
      .count (wb.mcycle)
   );

   csr_counter64 u_minstret (
      .clk   (clk),
      .reset (reset),
      .inc   (w_minstret_inc),
      .we_lo (wb.cnt_we[CNT_MINSTRET_LO]),
      .we_hi (wb.cnt_we[CNT_MINSTRET_HI]),
      .wdata (wb.cnt_wdata),
      .count (wb.minstret)
   );

endmodule

`default_nettype wire

// File: tb/tb_stage_wb.sv
// +----------------------------------------------------------------------------+
// | tb_stage_wb : self-checking bench for stage_wb against a behavioural model |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_stage_wb;
   import riscv_defines::*;

   localparam logic [31:0] RESET_PC = 32'h0000_1000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   stage_wb_if wb_if ();

   stage_wb #(.RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .wb    (wb_if)
   );

   always #5 clk = ~clk;

   // Model of the instruction sitting in WB plus the two counters.
   logic            m_valid;
   control_signal_t m_cs;
   logic [31:0]     m_pc, m_pcp4, m_mem, m_res;
   logic [4:0]      m_rd;
   trap_req_t       m_trap;
   logic [63:0]     m_mc, m_mi;

   function automatic logic [31:0] f_result();
      return (m_cs.resultsrc == RESULT_MEM) ? m_mem : m_res;
   endfunction
   function automatic logic f_retire();
      return m_valid && !m_trap.valid;
   endfunction
   function automatic logic f_regwrite();
      return f_retire() && m_cs.regwrite && (m_rd != 5'd0);
   endfunction
   function automatic trap_req_t f_trap();
      return m_valid ? m_trap : '0;
   endfunction

   task automatic clear_inputs();
      wb_if.valid_m          = 1'b0;
      wb_if.control_signal_m = '0;
      wb_if.pc_m             = '0;
      wb_if.pcplus4_m        = '0;
      wb_if.rd_m             = '0;
      wb_if.memresult_m      = '0;
      wb_if.result_m         = '0;
      wb_if.trap_req_m       = '0;
      wb_if.flush_w          = 1'b0;
      wb_if.cnt_we           = '0;
      wb_if.cnt_wdata        = '0;
      wb_if.cnt_inhibit      = '0;
   endtask

   // Advance one clock, updating the model from the inputs presented this cycle.
   task automatic tick();
      logic [63:0] mc_n, mi_n;
      logic        bubble;
      mc_n = wb_if.cnt_inhibit[0] ? m_mc : m_mc + 64'd1;
      mi_n = (f_retire() && !wb_if.cnt_inhibit[1]) ? m_mi + 64'd1 : m_mi;
      if (wb_if.cnt_we[0]) mc_n[31:0]  = wb_if.cnt_wdata;
      if (wb_if.cnt_we[1]) mc_n[63:32] = wb_if.cnt_wdata;
      if (wb_if.cnt_we[2]) mi_n[31:0]  = wb_if.cnt_wdata;
      if (wb_if.cnt_we[3]) mi_n[63:32] = wb_if.cnt_wdata;
      bubble = reset || wb_if.flush_w;
      if (reset) begin
         mc_n = 64'd0;
         mi_n = 64'd0;
      end
      m_valid = bubble ? 1'b0     : wb_if.valid_m;
      m_cs    = bubble ? '0       : wb_if.control_signal_m;
      m_pc    = bubble ? RESET_PC : wb_if.pc_m;
      m_pcp4  = bubble ? 32'd0    : wb_if.pcplus4_m;
      m_rd    = bubble ? 5'd0     : wb_if.rd_m;
      m_mem   = bubble ? 32'd0    : wb_if.memresult_m;
      m_res   = bubble ? 32'd0    : wb_if.result_m;
      m_trap  = bubble ? '0       : wb_if.trap_req_m;
      m_mc    = mc_n;
      m_mi    = mi_n;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_inputs();
      m_valid = 1'b0; m_cs = '0; m_trap = '0; m_mc = '0; m_mi = '0;
      m_pc = '0; m_pcp4 = '0; m_mem = '0; m_res = '0; m_rd = '0;
      repeat (3) tick();
      checks++; if (wb_if.result_w !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", wb_if.result_w); end
      checks++; if (wb_if.rd_w !== 5'd0) begin failures++; $display("FAIL reset_rd got=%h exp=0", wb_if.rd_w); end
      checks++; if (wb_if.regwrite_w !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b exp=0", wb_if.regwrite_w); end
      checks++; if (wb_if.pc_w !== RESET_PC) begin failures++; $display("FAIL reset_pc got=%h exp=%h", wb_if.pc_w, RESET_PC); end
      checks++; if (wb_if.trap_req_w !== '0) begin failures++; $display("FAIL reset_trap got=%h exp=0", wb_if.trap_req_w); end
      checks++; if (wb_if.retire_w !== 1'b0) begin failures++; $display("FAIL reset_retire got=%b exp=0", wb_if.retire_w); end
      checks++; if (wb_if.mcycle !== 64'd0) begin failures++; $display("FAIL reset_mcycle got=%h exp=0", wb_if.mcycle); end
      checks++; if (wb_if.minstret !== 64'd0) begin failures++; $display("FAIL reset_minstret got=%h exp=0", wb_if.minstret); end
      reset = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if (wb_if.mcycle !== 64'(i)) begin failures++; $display("FAIL mcycle_count got=%0d exp=%0d", wb_if.mcycle, i); end
         checks++; if (wb_if.minstret !== 64'd0) begin failures++; $display("FAIL minstret_idle got=%0d exp=0", wb_if.minstret); end
      end
   endtask

   task automatic test_load();
      logic [63:0] mi_before;
      clear_inputs();
      wb_if.valid_m                    = 1'b1;
      wb_if.control_signal_m.regwrite  = 1'b1;
      wb_if.control_signal_m.resultsrc = RESULT_MEM;
      wb_if.rd_m                       = 5'd5;
      wb_if.memresult_m                = 32'hDEAD_BEEF;
      wb_if.result_m                   = 32'h1111_1111;
      wb_if.pc_m                       = 32'h0000_0100;
      tick();
      clear_inputs();
      checks++; if (wb_if.result_w !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_result got=%h exp=deadbeef", wb_if.result_w); end
      checks++; if (wb_if.regwrite_w !== 1'b1) begin failures++; $display("FAIL load_regwrite got=%b exp=1", wb_if.regwrite_w); end
      checks++; if (wb_if.retire_w !== 1'b1) begin failures++; $display("FAIL load_retire got=%b exp=1", wb_if.retire_w); end
      checks++; if (wb_if.rd_w !== 5'd5) begin failures++; $display("FAIL load_rd got=%0d exp=5", wb_if.rd_w); end
      checks++; if (wb_if.pc_w !== 32'h0000_0100) begin failures++; $display("FAIL load_pc got=%h exp=00000100", wb_if.pc_w); end
      mi_before = m_mi;
      tick();
      checks++; if (wb_if.minstret !== mi_before + 64'd1) begin failures++; $display("FAIL load_minstret got=%0d exp=%0d", wb_if.minstret, mi_before + 64'd1); end
   endtask

   task automatic test_trap();
      logic [63:0] mi_before;
      trap_req_t   tr;
      tr = '{valid: 1'b1, cause: 5'd2, tval: 32'h0000_CAFE};
      clear_inputs();
      wb_if.valid_m                    = 1'b1;
      wb_if.control_signal_m.regwrite  = 1'b1;
      wb_if.control_signal_m.resultsrc = RESULT_ALU;
      wb_if.rd_m                       = 5'd7;
      wb_if.result_m                   = 32'h0000_0042;
      wb_if.trap_req_m                 = tr;
      tick();
      clear_inputs();
      checks++; if (wb_if.regwrite_w !== 1'b0) begin failures++; $display("FAIL trap_regwrite got=%b exp=0", wb_if.regwrite_w); end
      checks++; if (wb_if.retire_w !== 1'b0) begin failures++; $display("FAIL trap_retire got=%b exp=0", wb_if.retire_w); end
      checks++; if (wb_if.trap_req_w !== tr) begin failures++; $display("FAIL trap_req got=%h exp=%h", wb_if.trap_req_w, tr); end
      mi_before = m_mi;
      wb_if.valid_m                   = 1'b1;
      wb_if.control_signal_m.regwrite = 1'b1;
      wb_if.rd_m                      = 5'd0;
      tick();
      clear_inputs();
      checks++; if (wb_if.minstret !== mi_before) begin failures++; $display("FAIL trap_minstret got=%0d exp=%0d", wb_if.minstret, mi_before); end
      checks++; if (wb_if.regwrite_w !== 1'b0) begin failures++; $display("FAIL x0_regwrite got=%b exp=0", wb_if.regwrite_w); end
      checks++; if (wb_if.retire_w !== 1'b1) begin failures++; $display("FAIL x0_retire got=%b exp=1", wb_if.retire_w); end
   endtask

   task automatic test_flush();
      logic [63:0] mc_before;
      clear_inputs();
      wb_if.valid_m                   = 1'b1;
      wb_if.control_signal_m.regwrite = 1'b1;
      wb_if.rd_m                      = 5'd3;
      wb_if.result_m                  = 32'h0000_0055;
      wb_if.pc_m                      = 32'h0000_0200;
      wb_if.flush_w                   = 1'b1;
      mc_before = m_mc;
      tick();
      clear_inputs();
      checks++; if (wb_if.regwrite_w !== 1'b0) begin failures++; $display("FAIL flush_regwrite got=%b exp=0", wb_if.regwrite_w); end
      checks++; if (wb_if.pc_w !== RESET_PC) begin failures++; $display("FAIL flush_pc got=%h exp=%h", wb_if.pc_w, RESET_PC); end
      checks++; if (wb_if.retire_w !== 1'b0) begin failures++; $display("FAIL flush_retire got=%b exp=0", wb_if.retire_w); end
      checks++; if (wb_if.mcycle !== mc_before + 64'd1) begin failures++; $display("FAIL flush_mcycle got=%0d exp=%0d", wb_if.mcycle, mc_before + 64'd1); end
   endtask

   task automatic test_counter_carry();
      clear_inputs();
      wb_if.cnt_we = 4'b0011; wb_if.cnt_wdata = 32'd0;
      tick();
      wb_if.cnt_we = 4'b0001; wb_if.cnt_wdata = 32'hFFFF_FFFF;
      tick();
      checks++; if (wb_if.mcycle !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL carry_write got=%h exp=00000000ffffffff", wb_if.mcycle); end
      clear_inputs();
      tick();
      checks++; if (wb_if.mcycle !== 64'h0000_0001_0000_0000) begin failures++; $display("FAIL carry_inc got=%h exp=0000000100000000", wb_if.mcycle); end
      wb_if.cnt_we = 4'b0011; wb_if.cnt_wdata = 32'hFFFF_FFFF;
      tick();
      clear_inputs();
      checks++; if (wb_if.mcycle !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL full_write got=%h exp=ffffffffffffffff", wb_if.mcycle); end
      tick();
      checks++; if (wb_if.mcycle !== 64'd0) begin failures++; $display("FAIL wrap got=%h exp=0", wb_if.mcycle); end
   endtask

   task automatic test_inhibit();
      logic [63:0] mc0, mi0;
      clear_inputs();
      wb_if.valid_m     = 1'b1;
      wb_if.cnt_inhibit = 2'b11;
      mc0 = m_mc;
      mi0 = m_mi;
      repeat (4) tick();
      checks++; if (wb_if.mcycle !== mc0) begin failures++; $display("FAIL inhibit_mcycle got=%0d exp=%0d", wb_if.mcycle, mc0); end
      checks++; if (wb_if.minstret !== mi0) begin failures++; $display("FAIL inhibit_minstret got=%0d exp=%0d", wb_if.minstret, mi0); end
      wb_if.cnt_inhibit = 2'b00;
      wb_if.cnt_we      = 4'b0100;
      wb_if.cnt_wdata   = 32'hFFFF_FFFF;
      tick();
      checks++; if (wb_if.minstret[31:0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL minstret_lo_write got=%h exp=ffffffff", wb_if.minstret[31:0]); end
      wb_if.valid_m   = 1'b0;
      wb_if.cnt_we    = 4'b1000;
      wb_if.cnt_wdata = 32'h1234_5678;
      tick();
      clear_inputs();
      checks++; if (wb_if.minstret !== 64'h1234_5678_0000_0000) begin failures++; $display("FAIL minstret_hi_during_inc got=%h exp=1234567800000000", wb_if.minstret); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         wb_if.valid_m                    = 1'($urandom_range(0, 3) != 0);
         wb_if.control_signal_m.regwrite  = 1'($urandom_range(0, 1));
         wb_if.control_signal_m.resultsrc = result_src_e'($urandom_range(0, 3));
         wb_if.pc_m                       = $urandom;
         wb_if.pcplus4_m                  = wb_if.pc_m + 32'd4;
         wb_if.rd_m                       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         wb_if.memresult_m                = $urandom;
         wb_if.result_m                   = $urandom;
         wb_if.trap_req_m.valid           = 1'($urandom_range(0, 3) == 0);
         wb_if.trap_req_m.cause           = 5'($urandom);
         wb_if.trap_req_m.tval            = $urandom;
         wb_if.flush_w                    = 1'($urandom_range(0, 7) == 0);
         wb_if.cnt_we                     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0;
         wb_if.cnt_wdata                  = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
         wb_if.cnt_inhibit                = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'd0;
         reset                            = ($urandom_range(0, 63) == 0);
         tick();
         checks++; if (wb_if.result_w !== f_result()) begin failures++; $display("FAIL rnd_result n=%0d got=%h exp=%h", n, wb_if.result_w, f_result()); end
         checks++; if (wb_if.rd_w !== m_rd) begin failures++; $display("FAIL rnd_rd n=%0d got=%0d exp=%0d", n, wb_if.rd_w, m_rd); end
         checks++; if (wb_if.regwrite_w !== f_regwrite()) begin failures++; $display("FAIL rnd_regwrite n=%0d got=%b exp=%b", n, wb_if.regwrite_w, f_regwrite()); end
         checks++; if (wb_if.pc_w !== m_pc) begin failures++; $display("FAIL rnd_pc n=%0d got=%h exp=%h", n, wb_if.pc_w, m_pc); end
         checks++; if (wb_if.pcplus4_w !== m_pcp4) begin failures++; $display("FAIL rnd_pcplus4 n=%0d got=%h exp=%h", n, wb_if.pcplus4_w, m_pcp4); end
         checks++; if (wb_if.trap_req_w !== f_trap()) begin failures++; $display("FAIL rnd_trap n=%0d got=%h exp=%h", n, wb_if.trap_req_w, f_trap()); end
         checks++; if (wb_if.retire_w !== f_retire()) begin failures++; $display("FAIL rnd_retire n=%0d got=%b exp=%b", n, wb_if.retire_w, f_retire()); end
         checks++; if (wb_if.mcycle !== m_mc) begin failures++; $display("FAIL rnd_mcycle n=%0d got=%h exp=%h", n, wb_if.mcycle, m_mc); end
         checks++; if (wb_if.minstret !== m_mi) begin failures++; $display("FAIL rnd_minstret n=%0d got=%h exp=%h", n, wb_if.minstret, m_mi); end
      end
      reset = 1'b0;
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_load();
      test_trap();
      test_flush();
      test_counter_carry();
      test_inhibit();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
